arb_req_queue: RTL and testbench
================================

ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 SHALL have parameter REQ_WIDTH, default 16, number of requester ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, payload bits per request.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, entries per port FIFO; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_valid  input  REQ_WIDTH  per-port request valid.
REQ-007 SHALL have port in_ready  output  REQ_WIDTH  per-port FIFO not full.
REQ-008 SHALL have port in_data  input  REQ_WIDTH*DATA_WIDTH  per-port payload; port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port arb_req  output  REQ_WIDTH  per-port FIFO non-empty, to round-robin arbiter req.
REQ-010 SHALL have port arb_gnt  input  REQ_WIDTH  one-hot grant from arbiter, combinational in arb_req.
REQ-011 SHALL have port arb_port  input  $clog2(REQ_WIDTH)  encoded index of arb_gnt.
REQ-012 SHALL have port arb_en  output  1  arbiter pointer update strobe.
REQ-013 SHALL have port out_valid  output  1  output register holds a word.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.
REQ-015 SHALL have port out_data  output  DATA_WIDTH  payload of held word.
REQ-016 SHALL have port out_port  output  $clog2(REQ_WIDTH)  source port of held word.

Function
REQ-017 SHALL push port i FIFO when in_valid[i] & in_ready[i]; in_ready[i] = (count[i] != FIFO_DEPTH), from registered count, with no full-FIFO pass-through.
REQ-018 SHALL drive arb_req[i] = (count[i] != 0), registered state only, so an entry pushed at cycle N is requested from N+1.
REQ-019 SHALL define load = (|arb_req) & (~out_valid | out_ready); arb_en = load.
REQ-020 SHALL on load pop the FIFO selected by arb_gnt and register its head into out_data and arb_port into out_port, setting out_valid.
REQ-021 SHALL clear out_valid when out_ready & out_valid & ~load; hold out_data/out_port stable while out_valid & ~out_ready.
REQ-022 SHALL support simultaneous push and pop on one FIFO (count unchanged); pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH)+1.
REQ-023 SHALL sustain one output word per cycle with out_ready held high and any port non-empty.
REQ-024 SHALL have minimum latency of 2 cycles, from in handshake at N to out_valid at N+2.
REQ-025 SHALL ignore in_valid[i] while in_ready[i] is low, with no state change.

Reset
REQ-026 SHALL on rst_n low immediately zero all FIFO pointers and counts, out_valid, out_data and out_port.
REQ-027 SHALL drive in_ready = all ones, arb_req = 0 and arb_en = 0 during and after reset until the first push.
REQ-028 SHALL discard all queued words when reset is asserted mid-operation; no stale word appears after release.

Structure
REQ-029 SHALL take REQ_WIDTH/DATA_WIDTH/FIFO_DEPTH defaults and the port-index width function from the shared arbiter package.
REQ-030 SHALL implement per-port storage as a sub-module port_fifo (sync FIFO, count-based full/empty), generated REQ_WIDTH times.
REQ-031 SHALL leave RR_arbiter external, connected via arb_req/arb_gnt/arb_port/arb_en in the parent.

Verification
Benches SHALL use REQ_WIDTH=4, DATA_WIDTH=8, FIFO_DEPTH=4, with RR_arbiter attached, and SHALL cover the following scenarios.
REQ-032 Single word: port2 pushes 0xA5 at cycle N, out_ready=1 -> out_valid at N+2 with out_data=0xA5 and out_port=2; arb_en high exactly one cycle (N+1).
REQ-033 Fairness: ports 0-3 each push one word in the same cycle, out_ready=1 -> out_port sequence 0,1,2,3 on consecutive cycles.
REQ-034 Backpressure: out_ready=0, port0 offers 0x01..0x06 continuously -> exactly 5 accepted (1 held plus 4 queued); in_ready[0]=0 after; out_data stays 0x01; raising out_ready drains 0x01..0x05 in order.
REQ-035 Throughput: ports 1 and 3 kept full, out_ready=1 -> out_port alternates 1,3,1,3 with out_valid continuously high.
REQ-036 Mid-operation reset: with 3 words queued on port1, rst_n pulses low -> out_valid=0, arb_req=0, in_ready=4'b1111 at once; no word emerges after release until a new push.
REQ-037 Stall then release: out_valid=1 with out_ready=0 for 10 cycles -> out_data/out_port unchanged and arb_en=0 throughout.

Source files
------------

// File: rtl/arb_req_queue_pkg.sv
// Shared definitions for the arbitrated request queue: default sizing,
// port-index width helper and the FIFO update encoding.
package arb_req_queue_pkg;

    localparam int DEF_REQ_WIDTH  = 32'd16;
    localparam int DEF_DATA_WIDTH = 32'd32;
    localparam int DEF_FIFO_DEPTH = 32'd4;

    // {push, pop} pair applied to a FIFO in one cycle
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/arb_req_queue_port_fifo.sv
// Per-port synchronous FIFO with count-based full/empty; a write into a full
// FIFO and a read from an empty FIFO are dropped.
module port_fifo
    import arb_req_queue_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 32'd1;

    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic                  push_s;
    logic                  pop_s;
    fifo_op_e              op_s;

    assign full   = (count_r == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign push_s = push & ~full;
    assign pop_s  = pop & ~empty;
    assign op_s   = fifo_op_e'({push_s, pop_s});
    assign rdata  = mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case (op_s)
                FIFO_PUSH: count_r <= count_r + CNT_W'(1);
                FIFO_POP:  count_r <= count_r - CNT_W'(1);
                default:   count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/arb_req_queue.sv
// Per-port request FIFOs feeding a single registered output stage; the
// round-robin arbiter sits outside and picks which FIFO head is loaded.
module arb_req_queue
    import arb_req_queue_pkg::*;
#(
    parameter  int REQ_WIDTH  = DEF_REQ_WIDTH,
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int FIFO_DEPTH = DEF_FIFO_DEPTH,
    localparam int PORT_W     = idx_width(REQ_WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [REQ_WIDTH-1:0]            in_valid,
    output logic [REQ_WIDTH-1:0]            in_ready,
    input  logic [REQ_WIDTH*DATA_WIDTH-1:0] in_data,
    output logic [REQ_WIDTH-1:0]            arb_req,
    input  logic [REQ_WIDTH-1:0]            arb_gnt,
    input  logic [PORT_W-1:0]               arb_port,
    output logic                            arb_en,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PORT_W-1:0]               out_port
);

    logic [REQ_WIDTH-1:0]  full_s;
    logic [REQ_WIDTH-1:0]  empty_s;
    logic [REQ_WIDTH-1:0]  push_s;
    logic [REQ_WIDTH-1:0]  pop_s;
    logic [DATA_WIDTH-1:0] rdata_s [REQ_WIDTH];
    logic                  load_s;
    logic                  out_valid_r;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [PORT_W-1:0]     out_port_r;

    // Handshakes and requests come only from registered FIFO counts.
    assign in_ready = ~full_s;
    assign arb_req  = ~empty_s;
    assign push_s   = in_valid & ~full_s;
    assign load_s   = (|arb_req) & (~out_valid_r | out_ready);
    assign arb_en   = load_s;
    assign pop_s    = arb_gnt & {REQ_WIDTH{load_s}};

    generate
        for (genvar g = 0; g < REQ_WIDTH; g++) begin : gen_fifo
            port_fifo #(
                .DATA_WIDTH (DATA_WIDTH),
                .FIFO_DEPTH (FIFO_DEPTH)
            ) u_port_fifo (
                .clk   (clk),
                .rst_n (rst_n),
                .push  (push_s[g]),
                .pop   (pop_s[g]),
                .wdata (in_data[g*DATA_WIDTH +: DATA_WIDTH]),
                .rdata (rdata_s[g]),
                .full  (full_s[g]),
                .empty (empty_s[g])
            );
        end
    endgenerate

    // Output holding register: load the granted head, drain, or hold under stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_port_r  <= {PORT_W{1'b0}};
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= rdata_s[arb_port];
            out_port_r  <= arb_port;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_port  = out_port_r;

endmodule

// File: tb/tb_arb_req_queue.sv
// Directed bench for arb_req_queue with a behavioural round-robin arbiter
// attached; inputs change 1ns after the rising edge, outputs are read on the falling edge.
module tb_arb_req_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [3:0]  in_valid;
    logic [3:0]  in_ready;
    logic [31:0] in_data;
    logic [3:0]  arb_req;
    logic [3:0]  arb_gnt;
    logic [1:0]  arb_port;
    logic        arb_en;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic [1:0]  out_port;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0] rr_ptr;
    int         rr_idx;
    logic       rr_found;

    always #5 clk = ~clk;

    arb_req_queue #(.REQ_WIDTH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .arb_req(arb_req), .arb_gnt(arb_gnt), .arb_port(arb_port),
        .arb_en(arb_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_port(out_port)
    );

    // Round-robin arbiter: first requester at or after the pointer wins.
    always_comb begin
        arb_gnt  = 4'b0000;
        arb_port = 2'd0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < 4; k++) begin
            rr_idx = (int'(rr_ptr) + k) % 4;
            if (!rr_found && arb_req[rr_idx]) begin
                arb_gnt[rr_idx] = 1'b1;
                arb_port        = 2'(rr_idx);
                rr_found        = 1'b1;
            end
        end
    end

    // Pointer moves past the winner on each update strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= 2'd0;
        else if (arb_en) rr_ptr <= arb_port + 2'd1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        in_valid = 4'b0000; in_data = 32'h0; out_ready = 1'b0;
        rst_n = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        in_valid = 4'b0000; in_data = 32'h0; out_ready = 1'b1;
        rst_n = 1'b0;
        #3;
        vectors++; if (in_ready !== 4'b1111) begin miscompares++; $display("FAIL rst_in_ready got=%b exp=1111", in_ready); end
        vectors++; if (arb_req !== 4'b0000) begin miscompares++; $display("FAIL rst_arb_req got=%b exp=0000", arb_req); end
        vectors++; if (arb_en !== 1'b0) begin miscompares++; $display("FAIL rst_arb_en got=%b exp=0", arb_en); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL rst_out_data got=%h exp=00", out_data); end
        vectors++; if (out_port !== 2'd0) begin miscompares++; $display("FAIL rst_out_port got=%0d exp=0", out_port); end
        step(); step();
        rst_n = 1'b1;
        step(); step();
        sample();
        vectors++; if (in_ready !== 4'b1111) begin miscompares++; $display("FAIL post_rst_in_ready got=%b exp=1111", in_ready); end
        vectors++; if (arb_req !== 4'b0000) begin miscompares++; $display("FAIL post_rst_arb_req got=%b exp=0000", arb_req); end
        vectors++; if (arb_en !== 1'b0) begin miscompares++; $display("FAIL post_rst_arb_en got=%b exp=0", arb_en); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_rst_out_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_single_word();
        apply_reset();
        out_ready = 1'b1; in_valid = 4'b0100; in_data = 32'h00A5_0000;
        sample();
        vectors++; if (arb_en !== 1'b0) begin miscompares++; $display("FAIL single_en_n got=%b exp=0", arb_en); end
        step();
        in_valid = 4'b0000; in_data = 32'h0;
        sample();
        vectors++; if (arb_req !== 4'b0100) begin miscompares++; $display("FAIL single_req got=%b exp=0100", arb_req); end
        vectors++; if (arb_en !== 1'b1) begin miscompares++; $display("FAIL single_en_n1 got=%b exp=1", arb_en); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_n1 got=%b exp=0", out_valid); end
        step();
        sample();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid_n2 got=%b exp=1", out_valid); end
        vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL single_data got=%h exp=a5", out_data); end
        vectors++; if (out_port !== 2'd2) begin miscompares++; $display("FAIL single_port got=%0d exp=2", out_port); end
        vectors++; if (arb_en !== 1'b0) begin miscompares++; $display("FAIL single_en_n2 got=%b exp=0", arb_en); end
        step();
        sample();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_valid_n3 got=%b exp=0", out_valid); end
    endtask

    task automatic test_fairness();
        logic [7:0] exp_d;
        apply_reset();
        out_ready = 1'b1; in_valid = 4'b1111; in_data = 32'h1312_1110;
        sample(); step();
        in_valid = 4'b0000;
        sample();
        vectors++; if (arb_req !== 4'b1111) begin miscompares++; $display("FAIL fair_req got=%b exp=1111", arb_req); end
        step();
        for (int k = 0; k < 4; k++) begin
            exp_d = 8'h10 + 8'(k);
            sample();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL fair_valid[%0d] got=%b exp=1", k, out_valid); end
            vectors++; if (out_port !== 2'(k)) begin miscompares++; $display("FAIL fair_port[%0d] got=%0d exp=%0d", k, out_port, k); end
            vectors++; if (out_data !== exp_d) begin miscompares++; $display("FAIL fair_data[%0d] got=%h exp=%h", k, out_data, exp_d); end
            step();
        end
        sample();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fair_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [7:0] offer;
        int         accepted;
        logic       hs;
        apply_reset();
        out_ready = 1'b0; offer = 8'h01; accepted = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 4'b0001; in_data = {24'h0, offer};
            sample();
            hs = in_ready[0];
            step();
            if (hs) begin accepted++; offer = offer + 8'h01; end
        end
        sample();
        vectors++; if (accepted != 5) begin miscompares++; $display("FAIL bp_accepted got=%0d exp=5", accepted); end
        vectors++; if (in_ready[0] !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready got=%b exp=0", in_ready[0]); end
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid got=%b exp=1", out_valid); end
        vectors++; if (out_data !== 8'h01) begin miscompares++; $display("FAIL bp_held got=%h exp=01", out_data); end
        step();
        in_valid = 4'b0000; out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            sample();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_drain_valid[%0d] got=%b exp=1", k, out_valid); end
            vectors++; if (out_data !== 8'(k)) begin miscompares++; $display("FAIL bp_drain_data[%0d] got=%h exp=%h", k, out_data, 8'(k)); end
            step();
        end
        sample();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_throughput();
        logic [1:0] exp_p;
        logic [7:0] exp_d;
        apply_reset();
        out_ready = 1'b1; in_valid = 4'b1010; in_data = 32'h3300_1100;
        sample(); step();
        sample(); step();
        for (int k = 0; k < 8; k++) begin
            exp_p = (k % 2 == 0) ? 2'd1 : 2'd3;
            exp_d = (k % 2 == 0) ? 8'h11 : 8'h33;
            sample();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL tput_valid[%0d] got=%b exp=1", k, out_valid); end
            vectors++; if (out_port !== exp_p) begin miscompares++; $display("FAIL tput_port[%0d] got=%0d exp=%0d", k, out_port, exp_p); end
            vectors++; if (out_data !== exp_d) begin miscompares++; $display("FAIL tput_data[%0d] got=%h exp=%h", k, out_data, exp_d); end
            step();
        end
        in_valid = 4'b0000;
    endtask

    task automatic test_mid_reset();
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 4'b0010; in_data = {16'h0, 8'h40 + 8'(k), 8'h00};
            step();
        end
        in_valid = 4'b0000;
        sample();
        vectors++; if (arb_req !== 4'b0010) begin miscompares++; $display("FAIL mid_pre_req got=%b exp=0010", arb_req); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_valid got=%b exp=0", out_valid); end
        vectors++; if (arb_req !== 4'b0000) begin miscompares++; $display("FAIL mid_req got=%b exp=0000", arb_req); end
        vectors++; if (in_ready !== 4'b1111) begin miscompares++; $display("FAIL mid_in_ready got=%b exp=1111", in_ready); end
        vectors++; if (arb_en !== 1'b0) begin miscompares++; $display("FAIL mid_en got=%b exp=0", arb_en); end
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            sample();
            vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_stale_valid[%0d] got=%b exp=0", k, out_valid); end
            vectors++; if (arb_req !== 4'b0000) begin miscompares++; $display("FAIL mid_stale_req[%0d] got=%b exp=0000", k, arb_req); end
            step();
        end
        in_valid = 4'b0010; in_data = 32'h0000_7700;
        sample(); step();
        in_valid = 4'b0000;
        sample(); step();
        sample();
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL mid_new_valid got=%b exp=1", out_valid); end
        vectors++; if (out_data !== 8'h77) begin miscompares++; $display("FAIL mid_new_data got=%h exp=77", out_data); end
        vectors++; if (out_port !== 2'd1) begin miscompares++; $display("FAIL mid_new_port got=%0d exp=1", out_port); end
    endtask

    task automatic test_stall();
        apply_reset();
        out_ready = 1'b0; in_valid = 4'b1010; in_data = 32'h3C00_5C00;
        sample(); step();
        in_valid = 4'b0000;
        sample(); step();
        for (int k = 0; k < 10; k++) begin
            sample();
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid[%0d] got=%b exp=1", k, out_valid); end
            vectors++; if (out_data !== 8'h5C) begin miscompares++; $display("FAIL stall_data[%0d] got=%h exp=5c", k, out_data); end
            vectors++; if (out_port !== 2'd1) begin miscompares++; $display("FAIL stall_port[%0d] got=%0d exp=1", k, out_port); end
            vectors++; if (arb_en !== 1'b0) begin miscompares++; $display("FAIL stall_en[%0d] got=%b exp=0", k, arb_en); end
            step();
        end
        out_ready = 1'b1;
        sample();
        vectors++; if (arb_en !== 1'b1) begin miscompares++; $display("FAIL release_en got=%b exp=1", arb_en); end
        step();
        sample();
        vectors++; if (out_data !== 8'h3C) begin miscompares++; $display("FAIL release_data got=%h exp=3c", out_data); end
        vectors++; if (out_port !== 2'd3) begin miscompares++; $display("FAIL release_port got=%0d exp=3", out_port); end
        step();
        sample();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL release_empty got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fairness();
        test_backpressure();
        test_throughput();
        test_mid_reset();
        test_stall();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
